// File: rtl/cacheline_adaptor_pkg.sv
// Shared types for the cache-line <-> burst adaptor: FSM state encoding,
// line geometry and the beat index type.
package adaptor_types;

    // Beats per cache line (256-bit line / 64-bit beat).
    localparam int BEATS       = 4;
    // Byte-offset bits inside a 32-byte line; cleared on the burst address.
    localparam int OFFSET_BITS = 5;

    typedef logic [$clog2(BEATS)-1:0] beat_idx_t;

    typedef enum logic [2:0] {
        IDLE,
        RD_BURST,
        RD_DONE,
        WR_BURST,
        WR_DONE
    } state_t;

endpackage

// File: rtl/cacheline_adaptor.sv
// Cache-line adaptor: turns 256-bit line reads/writes from the cache into
// 4-beat 64-bit bursts on the memory side and reassembles read lines.
// Optional build macro ADAPTOR_TIMEOUT_EN adds a stall watchdog that aborts a
// burst after TIMEOUT_CYCLES consecutive stalled cycles and raises err_o.
module cacheline_adaptor
    import adaptor_types::*;
#(
    parameter int LINE_W         = 256,
    parameter int BURST_W        = 64,
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] address_i,
    input  logic [LINE_W-1:0] line_i,
    input  logic              read_i,
    input  logic              write_i,
    output logic [LINE_W-1:0] line_o,
    output logic              resp_o,
    output logic [ADDR_W-1:0] address_o,
    input  logic [BURST_W-1:0] burst_i,
    output logic [BURST_W-1:0] burst_o,
    output logic              read_o,
    output logic              write_o,
    input  logic              resp_i,
    output logic              err_o
);

    state_t             state_reg, state_next;
    beat_idx_t          beat_reg;
    logic [LINE_W-1:0]  line_reg;
    logic [LINE_W-1:0]  wbuf_reg;
    logic [ADDR_W-1:0]  addr_reg;
    logic               last_beat;
    logic               timeout;

    // Byte offset within the line never reaches the burst bus.
    logic [OFFSET_BITS-1:0] unused_addr_bits;
    assign unused_addr_bits = address_i[OFFSET_BITS-1:0];

    assign last_beat = (beat_reg == beat_idx_t'(BEATS - 1));

`ifdef ADAPTOR_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [STALL_W-1:0] stall_reg;
    logic               err_reg;
    logic               in_burst;

    assign in_burst = (state_reg == RD_BURST) || (state_reg == WR_BURST);
    assign timeout  = in_burst && !resp_i
                      && (stall_reg == STALL_W'(TIMEOUT_CYCLES - 1));
    assign err_o    = err_reg;

    // Watchdog: count consecutive stalled burst cycles; sticky error on expiry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            if (!in_burst || resp_i || (state_next != state_reg)) begin
                stall_reg <= '0;
            end else begin
                stall_reg <= stall_reg + 1'b1;
            end
            if (timeout) begin
                err_reg <= 1'b1;
            end
        end
    end
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

    assign timeout = 1'b0;
    assign err_o   = 1'b0;
`endif

    // Next-state logic; write requests win over reads in IDLE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (write_i) begin
                    state_next = WR_BURST;
                end else if (read_i) begin
                    state_next = RD_BURST;
                end
            end
            RD_BURST: begin
                if ((resp_i && last_beat) || timeout) begin
                    state_next = RD_DONE;
                end
            end
            WR_BURST: begin
                if ((resp_i && last_beat) || timeout) begin
                    state_next = WR_DONE;
                end
            end
            RD_DONE,
            WR_DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Request latching, beat counter and read-line assembly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_reg <= '0;
            line_reg <= '0;
            wbuf_reg <= '0;
            addr_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    beat_reg <= '0;
                    if (write_i || read_i) begin
                        addr_reg <= {address_i[ADDR_W-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
                    end
                    if (write_i) begin
                        wbuf_reg <= line_i;
                    end
                end
                RD_BURST: begin
                    if (resp_i) begin
                        line_reg[int'(beat_reg) * BURST_W +: BURST_W] <= burst_i;
                        beat_reg <= beat_reg + 1'b1;
                    end
                end
                WR_BURST: begin
                    if (resp_i) begin
                        beat_reg <= beat_reg + 1'b1;
                    end
                end
                default: beat_reg <= '0;
            endcase
        end
    end

    assign line_o    = line_reg;
    assign address_o = addr_reg;
    assign read_o    = (state_reg == RD_BURST);
    assign write_o   = (state_reg == WR_BURST);
    assign resp_o    = (state_reg == RD_DONE) || (state_reg == WR_DONE);
    assign burst_o   = (state_reg == WR_BURST)
                       ? wbuf_reg[int'(beat_reg) * BURST_W +: BURST_W]
                       : '0;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Self-checking bench for cacheline_adaptor: a cache-side driver issues line
// requests and pushes expectations into a scoreboard, a burst-memory model
// serves/absorbs beats, and a monitor checks each resp_o against the queue.
module tb_cacheline_adaptor;
    import adaptor_types::*;

    localparam int LINE_W  = 256;
    localparam int BURST_W = 64;
    localparam int ADDR_W  = 32;
    localparam int TO      = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic [ADDR_W-1:0]  address_i;
    logic [LINE_W-1:0]  line_i;
    logic               read_i;
    logic               write_i;
    logic [LINE_W-1:0]  line_o;
    logic               resp_o;
    logic [ADDR_W-1:0]  address_o;
    logic [BURST_W-1:0] burst_i;
    logic [BURST_W-1:0] burst_o;
    logic               read_o;
    logic               write_o;
    logic               resp_i;
    logic               err_o;

    cacheline_adaptor #(
        .LINE_W(LINE_W), .BURST_W(BURST_W), .ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst), .address_i(address_i), .line_i(line_i),
        .read_i(read_i), .write_i(write_i), .line_o(line_o), .resp_o(resp_o),
        .address_o(address_o), .burst_i(burst_i), .burst_o(burst_o),
        .read_o(read_o), .write_o(write_o), .resp_i(resp_i), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    // ---------------- reference and memory contents ----------------
    function automatic logic [255:0] pat(input logic [31:0] a);
        return {a * 32'd7 + 32'd3, ~a, a ^ 32'h5A5A_5A5A, a + 32'd1,
                a ^ 32'hC3C3_0F0F, a * 32'd13, ~(a + 32'd9), a ^ 32'h1234_5678};
    endfunction

    logic [255:0] ref_mem [logic [31:0]];   // what the cache believes is stored
    logic [255:0] mem     [logic [31:0]];   // what the burst memory actually holds

    function automatic logic [255:0] ref_line(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : pat(a);
    endfunction
    function automatic logic [255:0] mem_line(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : pat(a);
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct {
        bit           is_write;
        logic [31:0]  addr;
        logic [255:0] data;
        int           issue;
        int           exp_lat;
        int           exp_wcyc;
        bit           timeout;
        bit           exp_err;
        int           exp_bursts;
    } exp_t;

    exp_t sb[$];
    int   n_bursts_exp = 0;
    logic [255:0] line_o_model = '0;

    // ---------------- burst memory model ----------------
    int           stall_mode  = 0;   // 0 none, 1 random, 2 stalls before beat 2, 3 never answer
    int           stalls_left = 0;
    int           consec      = 0;
    int           mk          = 0;
    int           wcyc        = 0;
    logic [255:0] wline;
    int           bursts_done = 0;
    bit           last_was_write;
    logic [31:0]  last_addr;
    logic [255:0] last_wline;
    int           last_wcyc;

    always @(negedge clk) begin
        logic [255:0] src;
        bit go;
        if (rst) begin
            mk = 0; wcyc = 0; consec = 0;
            resp_i  = 1'b0;
            burst_i = '0;
        end else if (read_o || write_o) begin
            if (write_o) wcyc++;
            go = 1'b1;
            case (stall_mode)
                1: begin
                    go = ($urandom_range(0, 3) != 0) || (consec >= 3);
                end
                2: begin
                    if (mk == 2 && stalls_left > 0) begin
                        go = 1'b0;
                        stalls_left--;
                    end
                end
                3: go = 1'b0;
                default: go = 1'b1;
            endcase
            if (go) begin
                consec = 0;
                if (write_o) begin
                    wline[mk*64 +: 64] = burst_o;
                end else begin
                    src = mem_line(address_o);
                    burst_i = src[mk*64 +: 64];
                end
                resp_i = 1'b1;
                mk++;
                if (mk == BEATS) begin
                    bursts_done++;
                    last_was_write = write_o;
                    last_addr      = address_o;
                    if (write_o) begin
                        mem[address_o] = wline;
                        last_wline     = wline;
                        last_wcyc      = wcyc;
                    end
                    mk = 0;
                    wcyc = 0;
                end
            end else begin
                consec++;
                resp_i  = 1'b0;
                burst_i = {$urandom, $urandom};
            end
        end else begin
            // Outside a burst the adaptor must ignore whatever memory drives.
            mk = 0; wcyc = 0; consec = 0;
            resp_i  = ($urandom_range(0, 3) == 0);
            burst_i = {$urandom, $urandom};
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        if (!rst && resp_o) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_resp: got resp_o=1 at cycle %0d, expected no response", cycle);
            end else begin
                e = sb.pop_front();
                check("resp_address", address_o, e.addr);
                if (!e.timeout) begin
                    check("burst_count", bursts_done, e.exp_bursts);
                    check("burst_kind", last_was_write, e.is_write);
                    check("burst_address", last_addr, e.addr);
                end
                if (e.is_write) begin
                    if (!e.timeout) check("write_line", last_wline, e.data);
                end else begin
                    check("read_line", line_o, e.data);
                end
                check("err_o", err_o, e.exp_err);
                if (e.exp_lat >= 0)  check("latency", cycle - e.issue + 1, e.exp_lat);
                if (e.exp_wcyc >= 0) check("write_o_cycles", last_wcyc, e.exp_wcyc);
                $display("txn %s addr=0x%h resp at cycle %0d", e.is_write ? "WR" : "RD", e.addr, cycle);
            end
        end
    end

    // ---------------- cache-side driver ----------------
    task automatic issue(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [255:0] data, input int smode,
                         input int exp_lat, input int exp_wcyc, input bit to);
        exp_t e;
        logic [31:0] la;
        bit got;
        la = addr & 32'hFFFF_FFE0;
        @(negedge clk);
        stall_mode  = smode;
        stalls_left = 2;
        e.is_write = wr;
        e.addr     = la;
        e.issue    = cycle;
        e.exp_lat  = exp_lat;
        e.exp_wcyc = exp_wcyc;
        e.timeout  = to;
        e.exp_err  = to;
        if (wr) begin
            ref_mem[la] = data;
            e.data = data;
        end else if (to) begin
            e.data = line_o_model;
        end else begin
            e.data = ref_line(la);
            line_o_model = e.data;
        end
        if (!to) n_bursts_exp++;
        e.exp_bursts = n_bursts_exp;
        sb.push_back(e);
        address_i = addr;
        line_i    = data;
        read_i    = rd;
        write_i   = wr;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (resp_o) got = 1'b1;
        end
        read_i  = 1'b0;
        write_i = 1'b0;
        address_i = {$urandom};
        line_i    = {8{$urandom}};
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL resp_wait: got no resp_o within 200 cycles, expected a response");
            sb.delete();
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_line_o"}, line_o, '0);
        check({tag, "_burst_o"}, burst_o, '0);
        check({tag, "_address_o"}, address_o, '0);
        check({tag, "_resp_o"}, resp_o, 1'b0);
        check({tag, "_read_o"}, read_o, 1'b0);
        check({tag, "_write_o"}, write_o, 1'b0);
        check({tag, "_err_o"}, err_o, 1'b0);
    endtask

    initial begin
        logic [255:0] l1;
        logic [255:0] dline;
        rst = 1'b1;
        address_i = '0; line_i = '0; read_i = 1'b0; write_i = 1'b0;
        resp_i = 1'b0; burst_i = '0;
        #1;
        check_outputs_zero("reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Read with back-to-back beats: exact assembled line and 6-cycle latency.
        l1 = {{4{16'h4444}}, {4{16'h3333}}, {4{16'h2222}}, {4{16'h1111}}};
        mem[32'h0000_1220]     = l1;
        ref_mem[32'h0000_1220] = l1;
        issue(1'b1, 1'b0, 32'h0000_1234, '0, 0, 6, -1, 1'b0);
        check("plan_read_line", line_o, l1);

        // Write with two stalls before beat 2: write_o held 6 cycles, latency 8.
        dline = {8{32'hDEAD_BEEF}} ^ {32'h0, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7};
        issue(1'b0, 1'b1, 32'h0000_0040, dline, 2, 8, 6, 1'b0);

        // Read and write together: the write runs; the re-requested read sees its data.
        issue(1'b1, 1'b1, 32'h0000_0300, {8{32'hA5A5_0F0F}}, 1, -1, -1, 1'b0);
        issue(1'b1, 1'b0, 32'h0000_0300, '0, 1, -1, -1, 1'b0);

        // Reset in the middle of a read, after beat 1 has been captured.
        @(negedge clk);
        stall_mode = 0;
        address_i  = 32'h0000_0800;
        read_i     = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        l1 = ref_line(32'h0000_0800);
        check("pre_reset_beats", line_o[127:0], l1[127:0]);
        rst    = 1'b1;
        read_i = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        @(negedge clk);
        #1 rst = 1'b0;
        line_o_model = '0;
        repeat (3) @(negedge clk);
        issue(1'b1, 1'b0, 32'h0000_0800, '0, 0, 6, -1, 1'b0);

        // Evict + fill: write one line, then read a different one.
        issue(1'b0, 1'b1, 32'h0000_1000, {8{$urandom}}, 1, -1, -1, 1'b0);
        issue(1'b1, 1'b0, 32'h0000_2000, '0, 1, -1, -1, 1'b0);
        issue(1'b1, 1'b0, 32'h0000_1000, '0, 0, 6, -1, 1'b0);

        // Randomized traffic over a small set of lines so reads see earlier writes.
        for (int t = 0; t < 40; t++) begin
            int kind;
            logic [31:0] a;
            kind = $urandom_range(0, 2);
            a    = 32'h0000_4000 + {$urandom_range(0, 7), 5'(($urandom))};
            issue(kind != 1, kind != 0, a, {8{$urandom}}, $urandom_range(0, 1), -1, -1, 1'b0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

`ifdef ADAPTOR_TIMEOUT_EN
        // No memory answer: watchdog aborts, resp_o pulses with sticky err_o.
        issue(1'b1, 1'b0, 32'h0000_5000, '0, 3, 1 + TO + 1, -1, 1'b1);
        stall_mode = 0;
        repeat (4) @(negedge clk);
        check("err_sticky", err_o, 1'b1);
        rst = 1'b1;
        #1;
        check("err_cleared", err_o, 1'b0);
        @(negedge clk);
        rst = 1'b0;
`endif

        repeat (5) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
